// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
//   Shared types for the UART transmit-side queue.
//   - UART_BYTE_W : width of one serial data byte
//   - byte_t      : one data byte as carried between core, FIFO and transmitter
//   - txq_state_t : line-side launch FSM states of uart_tx_queue
// ----------------------------------------------------------------------------
package uart_pkg;

    localparam int unsigned UART_BYTE_W = 8;

    typedef logic [UART_BYTE_W-1:0] byte_t;

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT_BUSY,
        WAIT_DONE
    } txq_state_t;

endpackage

// File: rtl/byte_fifo.sv
// ----------------------------------------------------------------------------
// byte_fifo
//   Synchronous byte FIFO with 2**DEPTH_LOG2 entries. Pointers wrap naturally;
//   occupancy is tracked in a separate counter so full and empty are exact.
//   The head entry is presented combinationally on rd_data.
//
// Ports
//   clk      in   system clock
//   rst_n    in   asynchronous active-low reset (pointers and count cleared)
//   wr_en    in   push wr_data (ignored while full)
//   wr_data  in   byte to push
//   rd_en    in   pop the head entry (ignored while empty)
//   rd_data  out  current head entry
//   count    out  occupancy, 0..DEPTH
//   full     out  count == DEPTH
//   empty    out  count == 0
// ----------------------------------------------------------------------------
module byte_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [UART_BYTE_W-1:0] wr_data,
    input  logic                  rd_en,
    output logic [UART_BYTE_W-1:0] rd_data,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  full,
    output logic                  empty
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

    byte_t                 r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_count;

    logic                  w_wr;
    logic                  w_rd;

    assign w_wr = wr_en & ~full;
    assign w_rd = rd_en & ~empty;

    // Storage carries no reset; contents are only visible through count.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign rd_data = r_mem[r_rd_ptr];
    assign count   = r_count;
    // count never exceeds DEPTH, so its MSB alone marks full.
    assign full    = r_count[DEPTH_LOG2];
    assign empty   = (r_count == '0);

endmodule

// File: rtl/uart_tx_queue.sv
// ----------------------------------------------------------------------------
// uart_tx_queue
//   Byte queue in front of the UART transmitter. Core stores are accepted
//   through a valid/ready handshake into a byte_fifo and drained one byte at a
//   time via the transmitter's tx_start / sdata / tx_busy interface. If the
//   transmitter does not raise tx_busy within BUSY_WAIT_MAX cycles of a launch,
//   the same byte is launched again, so no byte is ever lost.
//
// Optional feature (macro UART_TX_QUEUE_OVERFLOW_EN):
//   adds ovf (sticky overflow flag, set by in_valid while not ready) and
//   ovf_clear (clears ovf; a simultaneous set wins). Without the macro, writes
//   to a full queue are silently dropped.
//
// Ports
//   clock      in   system clock
//   reset      in   asynchronous active-low reset
//   in_valid   in   core offers in_data
//   in_data    in   byte to enqueue
//   in_ready   out  queue not full
//   tx_start   out  one-cycle launch pulse to the transmitter
//   sdata      out  byte to the transmitter, held from launch to next dequeue
//   tx_busy    in   transmitter busy flag
//   count      out  FIFO occupancy, 0..DEPTH
//   empty      out  FIFO empty and launch FSM idle
//   ovf        out  sticky overflow flag        (UART_TX_QUEUE_OVERFLOW_EN)
//   ovf_clear  in   clear for ovf               (UART_TX_QUEUE_OVERFLOW_EN)
// ----------------------------------------------------------------------------
module uart_tx_queue
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2    = 4,
    parameter int unsigned BUSY_WAIT_MAX = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   in_valid,
    input  logic [UART_BYTE_W-1:0] in_data,
    output logic                   in_ready,
    output logic                   tx_start,
    output logic [UART_BYTE_W-1:0] sdata,
    input  logic                   tx_busy,
    output logic [DEPTH_LOG2:0]    count,
    output logic                   empty
`ifdef UART_TX_QUEUE_OVERFLOW_EN
    ,
    output logic                   ovf,
    input  logic                   ovf_clear
`endif
);

    localparam int unsigned RETRY_W = (BUSY_WAIT_MAX > 2) ? $clog2(BUSY_WAIT_MAX) : 1;
    localparam logic [RETRY_W-1:0] RETRY_LAST = RETRY_W'(BUSY_WAIT_MAX - 1);

    txq_state_t           r_state;
    logic                 r_tx_start;
    byte_t                r_sdata;
    logic [RETRY_W-1:0]   r_retry;

    byte_t                w_head;
    logic                 w_full;
    logic                 w_fifo_empty;
    logic                 w_deq;
    logic                 w_enq;

    assign in_ready = ~w_full;
    assign w_enq    = in_valid & in_ready;
    // Dequeue happens on the same edge that moves IDLE -> LAUNCH.
    assign w_deq    = (r_state == IDLE) & ~w_fifo_empty & ~tx_busy;

    byte_fifo #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk     (clock),
        .rst_n   (reset),
        .wr_en   (w_enq),
        .wr_data (in_data),
        .rd_en   (w_deq),
        .rd_data (w_head),
        .count   (count),
        .full    (w_full),
        .empty   (w_fifo_empty)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_tx_start <= 1'b0;
            r_sdata    <= '0;
            r_retry    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_deq) begin
                        r_state    <= LAUNCH;
                        r_tx_start <= 1'b1;
                        r_sdata    <= w_head;
                    end
                end
                LAUNCH: begin
                    r_tx_start <= 1'b0;
                    r_retry    <= '0;
                    r_state    <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (tx_busy) begin
                        r_state <= WAIT_DONE;
                    end else if (r_retry == RETRY_LAST) begin
                        // No acknowledge: relaunch the byte still held in r_sdata.
                        r_state    <= LAUNCH;
                        r_tx_start <= 1'b1;
                    end else begin
                        r_retry <= r_retry + 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (!tx_busy) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_tx_start <= 1'b0;
                end
            endcase
        end
    end

    assign tx_start = r_tx_start;
    assign sdata    = r_sdata;
    assign empty    = w_fifo_empty & (r_state == IDLE);

`ifdef UART_TX_QUEUE_OVERFLOW_EN
    logic r_ovf;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_ovf <= 1'b0;
        end else if (in_valid & ~in_ready) begin
            r_ovf <= 1'b1;
        end else if (ovf_clear) begin
            r_ovf <= 1'b0;
        end
    end

    assign ovf = r_ovf;
`endif

endmodule

// File: tb/tb_uart_tx_queue.sv
module tb_uart_tx_queue;
    import uart_pkg::*;

    logic        clock    = 1'b0;
    logic        reset    = 1'b0;
    logic        in_valid = 1'b0;
    byte_t       in_data  = '0;
    logic        in_ready;
    logic        tx_start;
    byte_t       sdata;
    logic        tx_busy;
    logic [4:0]  count;
    logic        empty;
`ifdef UART_TX_QUEUE_OVERFLOW_EN
    logic        ovf;
    logic        ovf_clear = 1'b0;
`endif

    // transmitter model state
    bit    m_busy     = 1'b0;
    bit    m_pend     = 1'b0;
    bit    force_busy = 1'b0;
    int    m_rem      = 0;
    int    busy_len   = 4;
    int    ignore_n   = 0;
    int    n_pulses   = 0;
    int    n_accepted = 0;
    byte_t ign_data   = '0;
    int    pulse_cyc[$];
    int    cyc        = 0;

    // scoreboard
    byte_t exp_q[$];
    int    n_chk  = 0;
    int    n_fail = 0;

    assign tx_busy = m_busy | force_busy;

    uart_tx_queue #(
        .DEPTH_LOG2    (4),
        .BUSY_WAIT_MAX (8)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .tx_start  (tx_start),
        .sdata     (sdata),
        .tx_busy   (tx_busy),
        .count     (count),
        .empty     (empty)
`ifdef UART_TX_QUEUE_OVERFLOW_EN
        ,
        .ovf       (ovf),
        .ovf_clear (ovf_clear)
`endif
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc++;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Transmitter model + scoreboard monitor. Busy rises one cycle after an
    // accepted tx_start and stays high for busy_len cycles.
    always @(negedge clock) begin
        if (m_rem > 0) begin
            m_rem--;
            if (m_rem == 0) m_busy = 1'b0;
        end
        if (m_pend) begin
            m_pend = 1'b0;
            m_busy = 1'b1;
            m_rem  = busy_len;
        end
        if (reset && tx_start === 1'b1) begin
            n_pulses++;
            pulse_cyc.push_back(cyc);
            if (ignore_n > 0) begin
                ignore_n--;
                ign_data = sdata;
            end else begin
                n_accepted++;
                m_pend = 1'b1;
                chk("sb_pending", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) chk("sb_byte", sdata, exp_q.pop_front());
            end
        end
    end

    task automatic wr(input byte_t d, input bit acc);
        @(negedge clock);
        in_valid = 1'b1;
        in_data  = d;
        chk("in_ready_at_write", in_ready, acc);
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        if (acc) exp_q.push_back(d);
    endtask

    task automatic wait_idle(input int maxc);
        bit ok;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clock);
            if (empty && !tx_busy && exp_q.size() == 0) break;
        end
        ok = empty && !tx_busy && (exp_q.size() == 0);
        chk("drain_timeout", ok, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int n0;
        int a0;
        int gap;

        // reset values
        repeat (3) @(negedge clock);
        chk("rst_tx_start", tx_start, 0);
        chk("rst_sdata", sdata, 0);
        chk("rst_count", count, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_empty", empty, 1);
        @(negedge clock);
        reset = 1'b1;

        // single byte, long busy period, latency check
        busy_len = 100;
        n0 = n_pulses;
        wr(8'hA5, 1);
        chk("lat_start_early", tx_start, 0);
        chk("lat_count1", count, 1);
        @(posedge clock);
        #1;
        chk("lat_start", tx_start, 1);
        chk("lat_sdata", sdata, 8'hA5);
        chk("lat_count0", count, 0);
        repeat (20) @(negedge clock);
        chk("busy_not_empty", empty, 0);
        wait_idle(300);
        chk("single_pulses", n_pulses - n0, 1);
        chk("single_sdata_hold", sdata, 8'hA5);
        chk("single_count", count, 0);

        // burst of 16 while transmitter held busy elsewhere
        busy_len   = 4;
        force_busy = 1'b1;
        n0 = n_pulses;
        for (int i = 0; i < 16; i++) wr(byte_t'(i), 1);
        chk("full_in_ready", in_ready, 0);
        chk("full_count", count, 16);
        wr(8'h77, 0);
        chk("full_drop_count", count, 16);
        chk("busy_idle_no_launch", n_pulses - n0, 0);

        // write held while full; dequeue frees a slot, write lands next edge
        @(negedge clock);
        in_valid   = 1'b1;
        in_data    = 8'h10;
        force_busy = 1'b0;
        @(posedge clock);
        #1;
        chk("fulldeq_count15", count, 15);
        chk("fulldeq_ready", in_ready, 1);
        chk("fulldeq_sdata", sdata, 8'h00);
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        exp_q.push_back(8'h10);
        chk("fulldeq_count16", count, 16);
        wait_idle(2000);
        chk("burst_pulses", n_pulses - n0, 17);

        // simultaneous enqueue and dequeue
        force_busy = 1'b1;
        wr(8'h21, 1);
        wr(8'h22, 1);
        wr(8'h23, 1);
        @(negedge clock);
        in_valid   = 1'b1;
        in_data    = 8'h24;
        force_busy = 1'b0;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        exp_q.push_back(8'h24);
        chk("simul_count", count, 3);
        chk("simul_sdata", sdata, 8'h21);
        wait_idle(500);

        // missing acknowledge: relaunch after BUSY_WAIT_MAX cycles
        ignore_n = 1;
        n0 = n_pulses;
        a0 = n_accepted;
        pulse_cyc.delete();
        wr(8'h5A, 1);
        wait_idle(300);
        chk("retry_pulses", n_pulses - n0, 2);
        chk("retry_accepted", n_accepted - a0, 1);
        chk("retry_ign_data", ign_data, 8'h5A);
        gap = (pulse_cyc.size() >= 2) ? (pulse_cyc[1] - pulse_cyc[0]) : -1;
        chk("retry_gap", gap, 9);

        // asynchronous reset during WAIT_DONE with 5 bytes queued
        busy_len = 100;
        n0 = n_pulses;
        for (int i = 0; i < 6; i++) wr(byte_t'(8'h31 + i), 1);
        repeat (10) @(negedge clock);
        chk("prerst_count", count, 5);
        chk("prerst_empty", empty, 0);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_tx_start", tx_start, 0);
        chk("arst_count", count, 0);
        chk("arst_in_ready", in_ready, 1);
        chk("arst_empty", empty, 1);
        exp_q.delete();
        @(negedge clock);
        reset = 1'b1;
        repeat (150) @(negedge clock);
        chk("postrst_pulses", n_pulses - n0, 1);
        chk("postrst_count", count, 0);

`ifdef UART_TX_QUEUE_OVERFLOW_EN
        busy_len   = 4;
        force_busy = 1'b1;
        chk("ovf_rst", ovf, 0);
        for (int i = 0; i < 16; i++) wr(byte_t'(8'h80 + i), 1);
        wr(8'h99, 0);
        chk("ovf_set", ovf, 1);
        repeat (5) @(negedge clock);
        chk("ovf_sticky", ovf, 1);
        @(negedge clock);
        ovf_clear = 1'b1;
        @(posedge clock);
        #1;
        ovf_clear = 1'b0;
        chk("ovf_cleared", ovf, 0);
        @(negedge clock);
        in_valid  = 1'b1;
        in_data   = 8'h9A;
        ovf_clear = 1'b1;
        @(posedge clock);
        #1;
        in_valid  = 1'b0;
        ovf_clear = 1'b0;
        chk("ovf_set_wins", ovf, 1);
        force_busy = 1'b0;
        wait_idle(2000);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_queue.md
Name: uart_tx_queue

Overview:
- Byte queue sitting directly upstream of the UART transmitter. It accepts bytes from the core (MMIO store path) through a valid/ready handshake and buffers them in a FIFO.
- It drains the FIFO into the transmitter one byte at a time using the transmitter's tx_start/sdata/tx_busy interface.
- It decouples core store bursts from the ~1 byte/10-bit-time serial rate.

Parameters:
- DEPTH_LOG2, 4, log2 of FIFO depth (depth = 16 entries)
- BUSY_WAIT_MAX, 8, cycles to wait for tx_busy rising after a launch before retrying the same byte

Ports:
- clock  input  1  system clock
- reset  input  1  asynchronous, active-low reset (queue reset while 0)
- in_valid  input  1  core offers in_data this cycle
- in_data  input  8  byte to enqueue
- in_ready  output  1  queue can accept (not full)
- tx_start  output  1  one-cycle launch pulse to transmitter
- sdata  output  8  byte to transmitter; stable while tx_start=1
- tx_busy  input  1  transmitter busy flag
- count  output  DEPTH_LOG2+1  current occupancy, 0..DEPTH
- empty  output  1  count==0 and FSM in IDLE (nothing pending on the line side)

Behaviour:
- Reset (reset=0, async): wr_ptr=rd_ptr=0, count=0, in_ready=1, tx_start=0, sdata=0, empty=1, FSM=IDLE, retry counter=0.
- Enqueue: when in_valid & in_ready, write in_data at wr_ptr and increment wr_ptr (wraps mod DEPTH). in_ready=(count!=DEPTH), registered-free (combinational from count).
- Pointers are DEPTH_LOG2 bits and wrap naturally. count is tracked separately.
- Simultaneous enqueue and dequeue: count unchanged.
- Full: in_valid is ignored, no write, no pointer change.
- FSM states:
  - IDLE: if count!=0 and tx_busy==0, go to LAUNCH. Dequeue the head into sdata register and advance rd_ptr in the same edge.
  - LAUNCH: tx_start=1 for exactly this one cycle; next state WAIT_BUSY; retry counter cleared.
  - WAIT_BUSY: if tx_busy==1, go to WAIT_DONE. Else increment retry counter; at BUSY_WAIT_MAX, go back to LAUNCH with the same sdata (byte never lost).
  - WAIT_DONE: when tx_busy==0, go to IDLE.
- Latency: byte written into an empty queue with idle transmitter gives tx_start high 2 cycles after the write edge (write, IDLE->LAUNCH, pulse).
- Back-to-back: the next launch is no earlier than 2 cycles after tx_busy falls.
- sdata holds its value from LAUNCH until the next dequeue.
- tx_busy already high in IDLE (transmitter used elsewhere): stay in IDLE.
- Reset mid-transmission: queue contents are discarded and tx_start is forced 0 immediately. No attempt is made to finish the byte on the line.

Optional Feature:
- Macro UART_TX_QUEUE_OVERFLOW_EN.
- When defined, add ports ovf (output 1) and ovf_clear (input 1).
  - ovf becomes sticky 1 on any cycle with in_valid & !in_ready.
  - ovf_clear=1 clears it; set wins over clear on the same cycle.
  - ovf resets to 0.
- Without the macro: the ports are absent and writes to a full queue are silently dropped (core is expected to poll in_ready).

Decomposition:
- Package uart_pkg: txq_state_t enum {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE}, typedef byte_t (logic [7:0]), localparam UART_BYTE_W=8.
- One sub-module: byte_fifo (storage array, pointers, count, full/empty). uart_tx_queue adds the FSM, retry counter and overflow logic.

Test Plan:
- Reset then single write 0xA5, transmitter model raises tx_busy 1 cycle after tx_start and holds it 100 cycles -> exactly one tx_start pulse, sdata=0xA5, count returns 0, empty=1 after tx_busy falls.
- Burst of 16 writes (0x00..0x0F) in consecutive cycles -> in_ready drops after the 16th write (minus any already dequeued). Bytes appear on sdata in order 0x00..0x0F, one launch per busy period.
- Write while full plus simultaneous dequeue in the same cycle -> write accepted, count stays 16, no data lost.
- Transmitter model ignores first tx_start (no tx_busy) -> after BUSY_WAIT_MAX=8 cycles a second pulse is issued with the same sdata. The byte is transmitted exactly once once busy is observed.
- Assert reset low mid-WAIT_DONE with 5 queued bytes -> tx_start=0, count=0, in_ready=1 immediately (asynchronously). No further launches after reset release.
- With UART_TX_QUEUE_OVERFLOW_EN, write a 17th byte into a full queue -> ovf=1 and stays 1. Pulse ovf_clear -> ovf=0. Overflow and clear in the same cycle -> ovf=1.
